// File: rtl/operand_forward_stage_pkg.sv
// Shared definitions for the operand forwarding stage.
//   - Default operand and register-address widths.
//   - Forwarding select codes reported for each resolved operand.
//   - Index of the hardwired-zero general register.
package operand_forward_stage_pkg;

  localparam int unsigned DataWDef = 32;
  localparam int unsigned AddrWDef = 5;

  // GR0 always reads as zero and is never a forwarding target.
  localparam int unsigned Gr0Idx = 0;

  typedef enum logic [1:0] {
    FwdRf  = 2'd0,
    FwdEx  = 2'd1,
    FwdMem = 2'd2,
    FwdWb  = 2'd3
  } fwd_sel_e;

endpackage

// File: rtl/operand_forward_stage_fwd_select.sv
// Operand forwarding mux for a single source register.
// Picks the youngest in-flight writer of src_i, with priority EX > MEM > WB,
// and falls back to the register file data.
// Ports:
//   src_i                          source register address
//   ex_/mem_/wb_ valid/le/rd       writer status of each downstream stage
//   ex_load_i                      EX holds a load (its result is not ready yet)
//   rf_/ex_/mem_/wb_ data_i        data candidates
//   data_o                         resolved operand
//   sel_o                          which candidate was chosen
module operand_forward_stage_fwd_select
  import operand_forward_stage_pkg::*;
#(
  parameter int unsigned DataW = DataWDef,
  parameter int unsigned AddrW = AddrWDef
) (
  input  logic [AddrW-1:0] src_i,
  input  logic             ex_valid_i,
  input  logic             ex_le_i,
  input  logic             ex_load_i,
  input  logic [AddrW-1:0] ex_rd_i,
  input  logic             mem_valid_i,
  input  logic             mem_le_i,
  input  logic [AddrW-1:0] mem_rd_i,
  input  logic             wb_valid_i,
  input  logic             wb_le_i,
  input  logic [AddrW-1:0] wb_rd_i,
  input  logic [DataW-1:0] rf_data_i,
  input  logic [DataW-1:0] ex_data_i,
  input  logic [DataW-1:0] mem_data_i,
  input  logic [DataW-1:0] wb_data_i,
  output logic [DataW-1:0] data_o,
  output fwd_sel_e         sel_o
);

  logic src_nonzero;
  logic ex_hit;
  logic mem_hit;
  logic wb_hit;

  assign src_nonzero = (src_i != AddrW'(Gr0Idx));

  // A load in EX has no data yet; the hazard logic stalls that case, so it
  // simply does not count as an EX writer here.
  assign ex_hit  = ex_valid_i & ex_le_i & ~ex_load_i & (ex_rd_i == src_i) & src_nonzero;
  assign mem_hit = mem_valid_i & mem_le_i & (mem_rd_i == src_i) & src_nonzero;
  assign wb_hit  = wb_valid_i & wb_le_i & (wb_rd_i == src_i) & src_nonzero;

  always_comb begin
    data_o = rf_data_i;
    sel_o  = FwdRf;
    if (!src_nonzero) begin
      // GR0 reads zero regardless of what the register file returns.
      data_o = '0;
    end else if (ex_hit) begin
      data_o = ex_data_i;
      sel_o  = FwdEx;
    end else if (mem_hit) begin
      data_o = mem_data_i;
      sel_o  = FwdMem;
    end else if (wb_hit) begin
      // Register file is written on the same edge, so its read data is stale.
      data_o = wb_data_i;
      sel_o  = FwdWb;
    end
  end

endmodule

// File: rtl/operand_forward_stage.sv
// Operand forwarding stage between the register file read ports and EX.
// Resolves RAW hazards by forwarding from EX/MEM/WB, detects load-use hazards,
// latches resolved operands into the ID/EX register, tracks in-flight
// destinations down to WB and drives the register file write port.
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   id_valid_i, ra_i, rb_i         ID instruction present and its source addresses
//   rf_pa_i, rf_pb_i               register file read data
//   id_rd_i, id_le_i, id_load_i    ID destination, write enable, load flag
//   flush_i                        squash the ID instruction
//   ex_result_i, mem_result_i      results of the instructions in EX and MEM
//   stall_o                        load-use hazard, upstream holds PC and IF/ID
//   ex_a_o, ex_b_o                 registered operands for EX
//   ex_valid_o, ex_rd_o, ex_le_o, ex_load_o   ID/EX control fields
//   wb_rd_o, wb_en_o, wb_data_o    register file write port
//   fwd_sel_a_o, fwd_sel_b_o       forwarding source chosen for each operand in ID
module operand_forward_stage
  import operand_forward_stage_pkg::*;
#(
  parameter int unsigned DataW = DataWDef,
  parameter int unsigned AddrW = AddrWDef
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             id_valid_i,
  input  logic [AddrW-1:0] ra_i,
  input  logic [AddrW-1:0] rb_i,
  input  logic [DataW-1:0] rf_pa_i,
  input  logic [DataW-1:0] rf_pb_i,
  input  logic [AddrW-1:0] id_rd_i,
  input  logic             id_le_i,
  input  logic             id_load_i,
  input  logic             flush_i,
  input  logic [DataW-1:0] ex_result_i,
  input  logic [DataW-1:0] mem_result_i,
  output logic             stall_o,
  output logic [DataW-1:0] ex_a_o,
  output logic [DataW-1:0] ex_b_o,
  output logic             ex_valid_o,
  output logic [AddrW-1:0] ex_rd_o,
  output logic             ex_le_o,
  output logic             ex_load_o,
  output logic [AddrW-1:0] wb_rd_o,
  output logic             wb_en_o,
  output logic [DataW-1:0] wb_data_o,
  output fwd_sel_e         fwd_sel_a_o,
  output fwd_sel_e         fwd_sel_b_o
);

  // ID/EX register
  logic             ex_valid_q, ex_valid_d;
  logic             ex_le_q,    ex_le_d;
  logic             ex_load_q,  ex_load_d;
  logic [AddrW-1:0] ex_rd_q,    ex_rd_d;
  logic [DataW-1:0] ex_a_q,     ex_a_d;
  logic [DataW-1:0] ex_b_q,     ex_b_d;

  // MEM and WB tracking (the load flag is no longer needed past EX)
  logic             mem_valid_q;
  logic             mem_le_q;
  logic [AddrW-1:0] mem_rd_q;
  logic             wb_valid_q;
  logic             wb_le_q;
  logic [AddrW-1:0] wb_rd_q;
  logic [DataW-1:0] wb_data_q;

  logic [DataW-1:0] op_a;
  logic [DataW-1:0] op_b;
  logic             hazard;
  logic             issue;

  operand_forward_stage_fwd_select #(
    .DataW(DataW),
    .AddrW(AddrW)
  ) u_fwd_a (
    .src_i      (ra_i),
    .ex_valid_i (ex_valid_q),
    .ex_le_i    (ex_le_q),
    .ex_load_i  (ex_load_q),
    .ex_rd_i    (ex_rd_q),
    .mem_valid_i(mem_valid_q),
    .mem_le_i   (mem_le_q),
    .mem_rd_i   (mem_rd_q),
    .wb_valid_i (wb_valid_q),
    .wb_le_i    (wb_le_q),
    .wb_rd_i    (wb_rd_q),
    .rf_data_i  (rf_pa_i),
    .ex_data_i  (ex_result_i),
    .mem_data_i (mem_result_i),
    .wb_data_i  (wb_data_q),
    .data_o     (op_a),
    .sel_o      (fwd_sel_a_o)
  );

  operand_forward_stage_fwd_select #(
    .DataW(DataW),
    .AddrW(AddrW)
  ) u_fwd_b (
    .src_i      (rb_i),
    .ex_valid_i (ex_valid_q),
    .ex_le_i    (ex_le_q),
    .ex_load_i  (ex_load_q),
    .ex_rd_i    (ex_rd_q),
    .mem_valid_i(mem_valid_q),
    .mem_le_i   (mem_le_q),
    .mem_rd_i   (mem_rd_q),
    .wb_valid_i (wb_valid_q),
    .wb_le_i    (wb_le_q),
    .wb_rd_i    (wb_rd_q),
    .rf_data_i  (rf_pb_i),
    .ex_data_i  (ex_result_i),
    .mem_data_i (mem_result_i),
    .wb_data_i  (wb_data_q),
    .data_o     (op_b),
    .sel_o      (fwd_sel_b_o)
  );

  // Load in EX whose data the ID instruction needs. It lasts one cycle: the
  // load moves on to MEM regardless and is forwarded from there.
  assign hazard = id_valid_i & ex_valid_q & ex_load_q & ex_le_q
                & (ex_rd_q != AddrW'(Gr0Idx))
                & ((ex_rd_q == ra_i) | (ex_rd_q == rb_i));

  // A flushed cycle is a redirect, so it must not also look like a hold.
  assign stall_o = hazard & ~flush_i;
  assign issue   = id_valid_i & ~flush_i & ~hazard;

  always_comb begin
    ex_valid_d = 1'b0;
    ex_le_d    = 1'b0;
    ex_load_d  = 1'b0;
    ex_rd_d    = '0;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    if (issue) begin
      ex_valid_d = 1'b1;
      ex_le_d    = id_le_i;
      ex_load_d  = id_load_i;
      ex_rd_d    = id_rd_i;
      ex_a_d     = op_a;
      ex_b_d     = op_b;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_valid_q  <= 1'b0;
      ex_le_q     <= 1'b0;
      ex_load_q   <= 1'b0;
      ex_rd_q     <= '0;
      ex_a_q      <= '0;
      ex_b_q      <= '0;
      mem_valid_q <= 1'b0;
      mem_le_q    <= 1'b0;
      mem_rd_q    <= '0;
      wb_valid_q  <= 1'b0;
      wb_le_q     <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_le_q     <= ex_le_d;
      ex_load_q   <= ex_load_d;
      ex_rd_q     <= ex_rd_d;
      ex_a_q      <= ex_a_d;
      ex_b_q      <= ex_b_d;
      // EX -> MEM -> WB shift never stalls.
      mem_valid_q <= ex_valid_q;
      mem_le_q    <= ex_le_q;
      mem_rd_q    <= ex_rd_q;
      wb_valid_q  <= mem_valid_q;
      wb_le_q     <= mem_le_q;
      wb_rd_q     <= mem_rd_q;
      wb_data_q   <= mem_result_i;
    end
  end

  assign ex_a_o     = ex_a_q;
  assign ex_b_o     = ex_b_q;
  assign ex_valid_o = ex_valid_q;
  assign ex_rd_o    = ex_rd_q;
  assign ex_le_o    = ex_le_q;
  assign ex_load_o  = ex_load_q;
  assign wb_rd_o    = wb_rd_q;
  assign wb_en_o    = wb_valid_q & wb_le_q;
  assign wb_data_o  = wb_data_q;

endmodule

// File: tb/tb_operand_forward_stage.sv
module tb_operand_forward_stage;
  import operand_forward_stage_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        id_valid_i;
  logic [4:0]  ra_i, rb_i, id_rd_i;
  logic [31:0] rf_pa_i, rf_pb_i, ex_result_i, mem_result_i;
  logic        id_le_i, id_load_i, flush_i;
  logic        stall_o, ex_valid_o, ex_le_o, ex_load_o, wb_en_o;
  logic [31:0] ex_a_o, ex_b_o, wb_data_o;
  logic [4:0]  ex_rd_o, wb_rd_o;
  fwd_sel_e    fwd_sel_a_o, fwd_sel_b_o;

  always #5 clk_i = ~clk_i;

  operand_forward_stage dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .id_valid_i  (id_valid_i),
    .ra_i        (ra_i),
    .rb_i        (rb_i),
    .rf_pa_i     (rf_pa_i),
    .rf_pb_i     (rf_pb_i),
    .id_rd_i     (id_rd_i),
    .id_le_i     (id_le_i),
    .id_load_i   (id_load_i),
    .flush_i     (flush_i),
    .ex_result_i (ex_result_i),
    .mem_result_i(mem_result_i),
    .stall_o     (stall_o),
    .ex_a_o      (ex_a_o),
    .ex_b_o      (ex_b_o),
    .ex_valid_o  (ex_valid_o),
    .ex_rd_o     (ex_rd_o),
    .ex_le_o     (ex_le_o),
    .ex_load_o   (ex_load_o),
    .wb_rd_o     (wb_rd_o),
    .wb_en_o     (wb_en_o),
    .wb_data_o   (wb_data_o),
    .fwd_sel_a_o (fwd_sel_a_o),
    .fwd_sel_b_o (fwd_sel_b_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: in-flight instructions, index 0 = EX, 1 = MEM, 2 = WB.
  typedef struct {
    bit       v;
    bit       le;
    bit       ld;
    bit [4:0] rd;
  } slot_t;

  slot_t       pipe[3];
  logic [31:0] m_wb_data;
  logic [31:0] m_ex_a;
  logic [31:0] m_ex_b;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '{v: 0, le: 0, ld: 0, rd: 0};
    m_wb_data = '0;
    m_ex_a    = '0;
    m_ex_b    = '0;
  endtask

  // Youngest writer wins; a load still in EX has no value to give.
  task automatic resolve(input logic [4:0] s, input logic [31:0] rf,
                         output logic [31:0] val, output logic [31:0] code);
    logic [31:0] cand[3];
    cand[0] = ex_result_i;
    cand[1] = mem_result_i;
    cand[2] = m_wb_data;
    val  = rf;
    code = 0;
    if (s == 0) begin
      val = 0;
      return;
    end
    for (int i = 0; i < 3; i++) begin
      if (pipe[i].v && pipe[i].le && pipe[i].rd == s && !(i == 0 && pipe[i].ld)) begin
        val  = cand[i];
        code = i + 1;
        return;
      end
    end
  endtask

  function automatic bit model_hazard();
    return id_valid_i && pipe[0].v && pipe[0].ld && pipe[0].le && pipe[0].rd != 0 &&
           (pipe[0].rd == ra_i || pipe[0].rd == rb_i);
  endfunction

  // One clock with the currently driven inputs, checked before and after the edge.
  task automatic step();
    logic [31:0] a, b, ca, cb;
    bit          hz;
    #1;
    hz = model_hazard();
    resolve(ra_i, rf_pa_i, a, ca);
    resolve(rb_i, rf_pb_i, b, cb);
    check("stall", {31'b0, stall_o}, {31'b0, hz && !flush_i});
    check("sel_a", {30'b0, fwd_sel_a_o}, ca);
    check("sel_b", {30'b0, fwd_sel_b_o}, cb);
    m_wb_data = mem_result_i;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    if (flush_i || hz || !id_valid_i) begin
      pipe[0] = '{v: 0, le: 0, ld: 0, rd: 0};
    end else begin
      pipe[0] = '{v: 1, le: id_le_i, ld: id_load_i, rd: id_rd_i};
      m_ex_a  = a;
      m_ex_b  = b;
    end
    @(posedge clk_i);
    #1;
    check("ex_valid", {31'b0, ex_valid_o}, {31'b0, pipe[0].v});
    check("ex_le", {31'b0, ex_le_o}, {31'b0, pipe[0].le});
    check("ex_load", {31'b0, ex_load_o}, {31'b0, pipe[0].ld});
    if (pipe[0].v) check("ex_rd", {27'b0, ex_rd_o}, {27'b0, pipe[0].rd});
    check("ex_a", ex_a_o, m_ex_a);
    check("ex_b", ex_b_o, m_ex_b);
    check("wb_en", {31'b0, wb_en_o}, {31'b0, pipe[2].v && pipe[2].le});
    if (pipe[2].v && pipe[2].le) check("wb_rd", {27'b0, wb_rd_o}, {27'b0, pipe[2].rd});
    check("wb_data", wb_data_o, m_wb_data);
  endtask

  task automatic drive_id(input bit v, input logic [4:0] ra, input logic [4:0] rb,
                          input logic [4:0] rd, input bit le, input bit ld, input bit fl);
    id_valid_i = v;
    ra_i       = ra;
    rb_i       = rb;
    id_rd_i    = rd;
    id_le_i    = le;
    id_load_i  = ld;
    flush_i    = fl;
  endtask

  task automatic rand_inputs();
    id_valid_i   = ($urandom_range(0, 9) < 8);
    ra_i         = 5'($urandom_range(0, 7));
    rb_i         = 5'($urandom_range(0, 7));
    id_rd_i      = 5'($urandom_range(0, 7));
    id_le_i      = ($urandom_range(0, 3) != 0);
    id_load_i    = ($urandom_range(0, 3) == 0);
    flush_i      = ($urandom_range(0, 9) == 0);
    rf_pa_i      = $urandom;
    rf_pb_i      = $urandom;
    ex_result_i  = $urandom;
    mem_result_i = $urandom;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ex_valid"}, {31'b0, ex_valid_o}, 32'd0);
    check({tag, "_wb_en"}, {31'b0, wb_en_o}, 32'd0);
    check({tag, "_stall"}, {31'b0, stall_o}, 32'd0);
    check({tag, "_ex_a"}, ex_a_o, 32'd0);
    check({tag, "_ex_b"}, ex_b_o, 32'd0);
  endtask

  initial begin
    model_reset();
    rst_ni = 1'b0;
    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      rand_inputs();
      @(posedge clk_i);
      #1;
      check_reset_outputs("rst");
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    rf_pa_i = 32'h0; rf_pb_i = 32'h0; ex_result_i = 32'h0; mem_result_i = 32'h0;

    // First valid ID after release is latched on the next edge
    drive_id(1, 0, 0, 5'd1, 0, 0, 0);
    step();
    check("first_valid", {31'b0, ex_valid_o}, 32'd1);

    // EX forward, then GR0 reads zero even with a GR0 writer in EX
    drive_id(1, 0, 0, 5'd3, 1, 0, 0);
    step();
    ex_result_i = 32'h14; rf_pa_i = 32'h99;
    drive_id(1, 5'd3, 0, 5'd0, 1, 0, 0);
    step();
    check("ex_fwd", ex_a_o, 32'h14);
    ex_result_i = 32'h77;
    drive_id(1, 5'd0, 0, 5'd9, 0, 0, 0);
    step();
    check("gr0_zero", ex_a_o, 32'h0);

    // Priority: WB=1, MEM=2, EX=3 all writing GR5
    drive_id(1, 0, 0, 5'd5, 1, 0, 0); step();
    drive_id(1, 0, 0, 5'd5, 1, 0, 0); step();
    mem_result_i = 32'h1;
    drive_id(1, 0, 0, 5'd5, 1, 0, 0); step();
    ex_result_i = 32'h3; mem_result_i = 32'h2; rf_pb_i = 32'hdead;
    drive_id(1, 0, 5'd5, 5'd6, 0, 0, 0); step();
    check("prio_ex", ex_b_o, 32'h3);
    // Same, with a bubble in EX: MEM wins over WB
    drive_id(1, 0, 0, 5'd5, 1, 0, 0); step();
    drive_id(1, 0, 0, 5'd5, 1, 0, 0); step();
    mem_result_i = 32'h1;
    drive_id(0, 0, 0, 5'd0, 0, 0, 0); step();
    mem_result_i = 32'h2;
    drive_id(1, 0, 5'd5, 5'd6, 0, 0, 0); step();
    check("prio_mem", ex_b_o, 32'h2);

    // WB forward over stale register file data
    drive_id(1, 0, 0, 5'd7, 1, 0, 0); step();
    drive_id(0, 0, 0, 5'd0, 0, 0, 0); step();
    mem_result_i = 32'h37;
    step();
    check("wb_en7", {31'b0, wb_en_o}, 32'd1);
    check("wb_rd7", {27'b0, wb_rd_o}, 32'd7);
    rf_pa_i = 32'h0; mem_result_i = 32'h0;
    drive_id(1, 5'd7, 0, 5'd8, 0, 0, 0); step();
    check("wb_fwd", ex_a_o, 32'h37);

    // Load-use: one stall cycle, then MEM forward
    drive_id(1, 0, 0, 5'd4, 1, 1, 0); step();
    drive_id(1, 5'd4, 0, 5'd10, 1, 0, 0);
    #1;
    check("lu_stall", {31'b0, stall_o}, 32'd1);
    step();
    check("lu_bubble", {31'b0, ex_valid_o}, 32'd0);
    mem_result_i = 32'h55; rf_pa_i = 32'h11;
    #1;
    check("lu_stall_once", {31'b0, stall_o}, 32'd0);
    step();
    check("lu_fwd", ex_a_o, 32'h55);

    // Flush beats stall; the load still retires
    drive_id(1, 0, 0, 5'd4, 1, 1, 0); step();
    drive_id(1, 5'd4, 0, 5'd11, 1, 0, 1);
    #1;
    check("fl_no_stall", {31'b0, stall_o}, 32'd0);
    step();
    check("fl_bubble", {31'b0, ex_valid_o}, 32'd0);
    drive_id(0, 0, 0, 5'd0, 0, 0, 0);
    step();
    check("fl_wb_en", {31'b0, wb_en_o}, 32'd1);
    check("fl_wb_rd", {27'b0, wb_rd_o}, 32'd4);

    // Randomized traffic, with an asynchronous reset in the middle
    for (int n = 0; n < 600; n++) begin
      if (n == 300) begin
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_wb_en", {31'b0, wb_en_o}, 32'd0);
        check("async_ex_valid", {31'b0, ex_valid_o}, 32'd0);
        @(posedge clk_i);
        #1;
        check_reset_outputs("midrst");
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
      end
      rand_inputs();
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
